// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 master: one aligned INCR burst per command, W/R streams passed through.
// Define AXI_BURST_MASTER_ERR_EN to report BRESP/RRESP errors on done_err (tied low otherwise).
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [DATA_WIDTH-1:0] wr_tdata,
    input  logic                  wr_tvalid,
    output logic                  wr_tready,
    output logic [DATA_WIDTH-1:0] rd_tdata,
    output logic                  rd_tvalid,
    input  logic                  rd_tready,
    output logic                  rd_tlast,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam logic [2:0]            AXSIZE     = 3'($clog2(STRB_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  awvalid_q, arvalid_q, bready_q, done_valid_q;
    logic                  w_hs, r_hs, w_last;

    assign cmd_ready     = (state_q == S_IDLE);
    assign done_valid    = done_valid_q;

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AXSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = AXSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;

    // Data channels are pure passthroughs, gated so nothing leaks outside the owning state.
    assign w_last        = (beat_cnt_q == len_q);
    assign m_axi_wdata   = wr_tdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == S_W) && wr_tvalid;
    assign wr_tready     = (state_q == S_W) && m_axi_wready;
    assign m_axi_wlast   = (state_q == S_W) && w_last;
    assign m_axi_bready  = bready_q;

    assign rd_tdata      = m_axi_rdata;
    assign rd_tvalid     = (state_q == S_R) && m_axi_rvalid;
    assign m_axi_rready  = (state_q == S_R) && rd_tready;
    assign rd_tlast      = (state_q == S_R) && m_axi_rlast;

    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign r_hs          = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            beat_cnt_q   <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    addr_q     <= cmd_addr & ALIGN_MASK;
                    len_q      <= cmd_len;
                    id_q       <= cmd_id;
                    beat_cnt_q <= '0;
                    if (cmd_write) begin
                        state_q   <= S_AW;
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q   <= S_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_AW: if (m_axi_awready) begin
                    awvalid_q <= 1'b0;
                    state_q   <= S_W;
                end
                S_W: if (w_hs) begin
                    if (w_last) begin
                        state_q  <= S_B;
                        bready_q <= 1'b1;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
                S_B: if (m_axi_bvalid) begin
                    bready_q     <= 1'b0;
                    done_valid_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_AR: if (m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    state_q   <= S_R;
                end
                S_R: if (r_hs && m_axi_rlast) begin
                    done_valid_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_BURST_MASTER_ERR_EN
    logic rerr_q, done_err_q;

    // rerr_q is sticky across read beats and cleared when the next command is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rerr_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            done_err_q <= 1'b0;
            if (cmd_valid && cmd_ready)
                rerr_q <= 1'b0;
            else if (r_hs)
                rerr_q <= rerr_q | (m_axi_rresp != 2'b00);
            if ((state_q == S_B) && m_axi_bvalid)
                done_err_q <= (m_axi_bresp != 2'b00);
            if (r_hs && m_axi_rlast)
                done_err_q <= rerr_q | (m_axi_rresp != 2'b00);
        end
    end

    assign done_err = done_err_q;
`else
    assign done_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_bresp, m_axi_rresp};

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Command-driven AXI4 master that sits directly upstream of the team's AXI4 RAM slave and drives its AW/W/B/AR/R channels. It accepts one read or write command at a time and issues a single aligned INCR burst of up to 256 full-width beats. Write data comes in on a stream input and read data leaves on a stream output. Each command completes with a one-cycle done pulse that carries error status.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; multiple of 8.
- ADDR_WIDTH, 8, AXI byte-address width.
- ID_WIDTH, 8, AXI ID width.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accept.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus 1.
- cmd_id  in  ID_WIDTH  AXI ID for the burst.
- wr_tdata  in  DATA_WIDTH  write beat data.
- wr_tvalid  in  1  write beat valid.
- wr_tready  out  1  write beat accept.
- rd_tdata  out  DATA_WIDTH  read beat data.
- rd_tvalid  out  1  read beat valid.
- rd_tready  in  1  read beat accept.
- rd_tlast  out  1  final read beat.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  error flag, qualified by done_valid.
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*: full AXI4 master set (id, addr, len, size, burst, lock, cache, prot, valid, ready, data, strb, last, resp), widths per parameters.

## Operation
- States: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr, len, id and direction. Go to AW if cmd_write, else AR.
- AW/AR: hold awvalid/arvalid with latched fields until the ready handshake. Then go to W or R.
- Address fields: addr = cmd_addr with the low log2(STRB_WIDTH) bits forced to 0.
- Fixed fields: size = log2(STRB_WIDTH), burst = 2'b01 (INCR), lock/cache/prot = 0.
- The block does not split bursts. Address wrap past 2^ADDR_WIDTH is the caller's responsibility.
- W: combinational passthrough.
  - wvalid = wr_tvalid, wr_tready = wready, wdata = wr_tdata.
  - wstrb = all ones.
  - wlast = (beat_cnt == len).
  - beat_cnt increments on each W handshake; after the last handshake go to B.
- B: bready=1. On bvalid, capture bresp and go to IDLE, pulsing done.
- R: combinational passthrough.
  - rd_tvalid = rvalid, rready = rd_tready, rd_tdata = rdata.
  - rd_tlast = rlast.
  - On the rvalid&&rready&&rlast handshake, go to IDLE and pulse done.
- Outside their owning state, all passthrough valids/readies are 0. wr_tready=0 outside W; rd_tvalid=0 outside R.
- Only one transaction is outstanding; AW and W never overlap.

## Timing
- Reset values: state=IDLE, cmd_ready=1, done_valid=0, done_err=0, awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0, wr_tready=0, rd_tvalid=0, rd_tlast=0.
- cmd_ready is derived from the state register; there is no combinational path from cmd_valid.
- Command accepted at edge N: awvalid/arvalid is high in cycle N+1.
- done_valid is high for exactly the cycle after the final B or R handshake. cmd_ready returns in that same cycle.
- A new command may be accepted in the done cycle.
- Stalls: wr_tvalid low or rd_tready low stalls the beat indefinitely; no data is lost or duplicated.
- Reset mid-operation: the next edge forces IDLE and all valids low, and the burst is abandoned. The slave shares rst and resets with it.
- beat_cnt is 8 bits and never wraps, because len ≤ 255.

## Configuration
- AXI_BURST_MASTER_ERR_EN defined:
  - done_err = (bresp != 0) for writes.
  - done_err = OR over beats of (rresp != 0) for reads, accumulated in a sticky register cleared on command accept.
- AXI_BURST_MASTER_ERR_EN undefined:
  - done_err tied to 0; bresp and rresp are ignored.
  - No error registers are synthesized.

## Test plan
- Single write: addr 0x10, len 0, data 0xDEADBEEF. Then read at addr 0x10 -> rd_tdata = 0xDEADBEEF with rd_tlast=1, and one done_valid per command with done_err=0.
- Burst write: addr 0x20, len 3, data 1,2,3,4. Then burst read -> rd_tdata 1,2,3,4, rd_tlast only on the 4th beat, awlen=arlen=3, awsize=2.
- Backpressure: toggle rd_tready every cycle and gap wr_tvalid randomly on a len 7 burst -> data intact and in order, with no extra or missing handshakes.
- Alignment: cmd_addr 0x13 -> awaddr/araddr = 0x10.
- Error (macro on): slave model returns rresp=2'b10 on beat 2 of a 4-beat read -> done_err=1. The next clean command gives done_err=0. With the macro off, done_err stays 0.
- Reset after 2 of 4 write beats -> next cycle state is IDLE, cmd_ready=1, all valids 0, and a subsequent write/read pair succeeds.
